// File: rtl/bf_io_port_if.sv
// ============================================================================
// bf_io_port_if : CPU io_* handshake plus host TX/RX byte streams.
// Revision 1.0
// ============================================================================
`default_nettype none

interface bf_io_port_if;
  logic       io_req;
  logic       io_dir;
  logic [7:0] io_wdata;
  logic       io_ack;
  logic [7:0] io_rdata;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_eof;

  modport master (
    output io_req, io_dir, io_wdata, tx_ready, rx_valid, rx_data, rx_eof,
    input  io_ack, io_rdata, tx_valid, tx_data, rx_ready
  );

  modport slave (
    input  io_req, io_dir, io_wdata, tx_ready, rx_valid, rx_data, rx_eof,
    output io_ack, io_rdata, tx_valid, tx_data, rx_ready
  );
endinterface

`default_nettype wire

// File: rtl/bf_io_port.sv
// ============================================================================
// bf_io_port : four-phase byte I/O responder with TX and RX FIFOs.
// Revision 1.0
// ============================================================================
`default_nettype none

module bf_io_port #(
  parameter int         fifo_aw   = 2,
  parameter logic [7:0] eof_value = 8'h00
) (
  input  wire logic    clk,
  input  wire logic    rst,
  bf_io_port_if.slave  bus
);

  localparam int AW    = fifo_aw;
  localparam int CW    = fifo_aw + 1;
  localparam int DEPTH = 1 << fifo_aw;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT_W = 2'd1,
    S_WAIT_R = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            io_ack_q, io_ack_d;
  logic [7:0]      io_rdata_q, io_rdata_d;
  logic [7:0]      wbyte_q, wbyte_d;

  logic [7:0]      tx_mem_q [DEPTH];
  logic [AW-1:0]   tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [7:0]      rx_mem_q [DEPTH];
  logic [AW-1:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;

  logic            tx_full, rx_empty;
  logic            tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]      tx_push_data;

  // Flags come only from registered counts, so there is no same-cycle bypass.
  assign tx_full  = (tx_cnt_q == CW'(DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_pop   = (tx_cnt_q != '0) && bus.tx_ready;
  assign rx_push  = (rx_cnt_q != CW'(DEPTH)) && bus.rx_valid;

  assign bus.io_ack   = io_ack_q;
  assign bus.io_rdata = io_rdata_q;
  assign bus.tx_valid = (tx_cnt_q != '0);
  assign bus.tx_data  = tx_mem_q[tx_rp_q];
  assign bus.rx_ready = (rx_cnt_q != CW'(DEPTH));

  always_comb begin
    state_d      = state_q;
    io_ack_d     = io_ack_q;
    io_rdata_d   = io_rdata_q;
    wbyte_d      = wbyte_q;
    tx_push      = 1'b0;
    tx_push_data = wbyte_q;
    rx_pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.io_req && bus.io_dir) begin
          if (!tx_full) begin
            tx_push      = 1'b1;
            tx_push_data = bus.io_wdata;
            io_ack_d     = 1'b1;
            state_d      = S_ACK;
          end else begin
            wbyte_d = bus.io_wdata;
            state_d = S_WAIT_W;
          end
        end else if (bus.io_req) begin
          state_d = S_WAIT_R;
        end
      end
      S_WAIT_W: begin
        if (!tx_full) begin
          tx_push  = 1'b1;
          io_ack_d = 1'b1;
          state_d  = S_ACK;
        end
      end
      S_WAIT_R: ;
      S_ACK: begin
        if (!bus.io_req) begin
          io_ack_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Reads in IDLE and WAIT_R share one service path; RX data beats EOF.
    if ((state_q == S_WAIT_R) || (state_q == S_IDLE && bus.io_req && !bus.io_dir)) begin
      if (!rx_empty) begin
        rx_pop     = 1'b1;
        io_rdata_d = rx_mem_q[rx_rp_q];
        io_ack_d   = 1'b1;
        state_d    = S_ACK;
      end else if (bus.rx_eof) begin
        io_rdata_d = eof_value;
        io_ack_d   = 1'b1;
        state_d    = S_ACK;
      end
    end

    tx_wp_d  = tx_wp_q + AW'(tx_push);
    tx_rp_d  = tx_rp_q + AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_wp_d  = rx_wp_q + AW'(rx_push);
    rx_rp_d  = rx_rp_q + AW'(rx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      io_ack_q   <= 1'b0;
      io_rdata_q <= 8'h00;
      wbyte_q    <= 8'h00;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      tx_cnt_q   <= '0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      io_ack_q   <= io_ack_d;
      io_rdata_q <= io_rdata_d;
      wbyte_q    <= wbyte_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      if (tx_push) tx_mem_q[tx_wp_q] <= tx_push_data;
      if (rx_push) rx_mem_q[rx_wp_q] <= bus.rx_data;
    end
  end

endmodule

`default_nettype wire
